note_envelope: RTL and testbench

- Downstream consumer of the sine reader stage. Paces it and applies a per-note amplitude envelope before the sample reaches the codec path.
- On each codec sample request, pulses generate_next and waits for the sine stage's sample_ready/sample.
- Scales that sample by an attack/sustain/release envelope and presents the result with a one-cycle valid pulse.

---
 rtl/note_envelope.sv | 126 ++++++++++++
 tb/tb_note_envelope.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/note_envelope.sv
// Paces the sine stage one sample per codec request and scales each returned
// sample by an attack/sustain/release envelope before handing it to the codec.
module note_envelope #(
    parameter int ENV_WIDTH    = 8,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 note_on,
    input  logic                 note_off,
    input  logic                 new_sample_request,
    input  logic                 sample_ready,
    input  logic [15:0]          sample,
    output logic                 generate_next,
    output logic [15:0]          out_sample,
    output logic                 out_valid,
    output logic [ENV_WIDTH-1:0] env_level,
    output logic [1:0]           state,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam int PW = 17 + ENV_WIDTH;
    localparam logic [ENV_WIDTH:0] FULL = {1'b0, {ENV_WIDTH{1'b1}}};
    localparam logic [ENV_WIDTH:0] ATK  = (ENV_WIDTH+1)'(ATTACK_STEP);
    localparam logic [ENV_WIDTH:0] REL  = (ENV_WIDTH+1)'(RELEASE_STEP);

    state_t                 state_q, state_d;
    logic [ENV_WIDTH-1:0]   env_q, env_d;
    logic                   pending_q;
    logic                   generate_next_q;
    logic [15:0]            out_sample_q;
    logic                   out_valid_q;
    logic                   overrun_q;

    logic                   capture;
    logic [ENV_WIDTH:0]     atk_sum;
    logic signed [PW-1:0]   smp_ext, env_ext, prod;
    logic [15:0]            scaled;

    assign capture = sample_ready && pending_q;

    // env is zero-extended so the multiply stays signed without flipping its sign
    assign smp_ext = PW'($signed(sample));
    assign env_ext = PW'({1'b0, env_q});
    assign prod    = smp_ext * env_ext;
    assign scaled  = 16'(prod >>> ENV_WIDTH);

    assign atk_sum = {1'b0, env_q} + ATK;

    always_comb begin
        env_d   = env_q;
        state_d = state_q;
        if (capture) begin
            case (state_q)
                S_ATTACK: begin
                    if (atk_sum >= FULL) begin
                        env_d   = FULL[ENV_WIDTH-1:0];
                        state_d = S_SUSTAIN;
                    end else begin
                        env_d = atk_sum[ENV_WIDTH-1:0];
                    end
                end
                S_RELEASE: begin
                    if ({1'b0, env_q} <= REL) begin
                        env_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        env_d = env_q - REL[ENV_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
        // Note control overrides any envelope-driven state change; env keeps its update.
        if (note_off && (state_q == S_ATTACK || state_q == S_SUSTAIN))
            state_d = S_RELEASE;
        else if (note_on && !note_off && (state_q == S_IDLE || state_q == S_RELEASE))
            state_d = S_ATTACK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            env_q           <= '0;
            pending_q       <= 1'b0;
            generate_next_q <= 1'b0;
            out_sample_q    <= '0;
            out_valid_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            generate_next_q <= 1'b0;
            out_valid_q     <= 1'b0;
            state_q         <= state_d;
            env_q           <= env_d;
            if (new_sample_request) begin
                if (!pending_q) begin
                    generate_next_q <= 1'b1;
                    pending_q       <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            if (capture) begin
                out_sample_q <= scaled;
                out_valid_q  <= 1'b1;
                pending_q    <= 1'b0;
            end
        end
    end

    assign generate_next = generate_next_q;
    assign out_sample    = out_sample_q;
    assign out_valid     = out_valid_q;
    assign env_level     = env_q;
    assign state         = state_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_note_envelope.sv
// Directed bench for note_envelope with a 2-cycle sine-stage model and a
// scoreboard of expected enveloped samples.
module tb_note_envelope;

    localparam int EW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        note_on = 1'b0, note_off = 1'b0, req = 1'b0;
    logic        sample_ready;
    logic [15:0] sample = '0;
    logic        generate_next, out_valid, overrun;
    logic [15:0] out_sample;
    logic [EW-1:0] env_level;
    logic [1:0]  state;

    note_envelope #(.ENV_WIDTH(EW), .ATTACK_STEP(16), .RELEASE_STEP(4)) dut (
        .clk(clk), .reset(rst_n), .note_on(note_on), .note_off(note_off),
        .new_sample_request(req), .sample_ready(sample_ready), .sample(sample),
        .generate_next(generate_next), .out_sample(out_sample), .out_valid(out_valid),
        .env_level(env_level), .state(state), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Sine stage: sample_ready two cycles after generate_next; not reset with the DUT.
    logic sr1 = 1'b0, sr2 = 1'b0;
    always @(posedge clk) begin
        sr1 <= generate_next;
        sr2 <= sr1;
    end
    assign sample_ready = sr2;

    typedef struct {
        logic signed [15:0] smp;
        logic [EW-1:0]      env;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, failures = 0;
    int   m_env = 0, m_st = 0;
    int   gcnt, vcnt;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: scale with the pre-update env, then advance the envelope.
    task automatic model_sample(input int val, output exp_t e);
        longint p;
        p = longint'(val) * longint'(m_env);
        e.smp = 16'(p >>> EW);
        case (m_st)
            1: if (m_env + 16 >= 255) begin m_env = 255; m_st = 2; end else m_env += 16;
            3: if (m_env <= 4) begin m_env = 0; m_st = 0; end else m_env -= 4;
            default: ;
        endcase
        e.env = EW'(m_env);
    endtask

    task automatic note(input logic on, input logic off);
        @(negedge clk);
        note_on = on; note_off = off;
        if (off && (m_st == 1 || m_st == 2)) m_st = 3;
        else if (on && !off && (m_st == 0 || m_st == 3)) m_st = 1;
        @(negedge clk);
        note_on = 1'b0; note_off = 1'b0;
    endtask

    task automatic req_step(input int val);
        exp_t e;
        @(negedge clk);
        sample = 16'(val);
        req = 1'b1;
        model_sample(val, e);
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        chk("gen_after_req", 32'(generate_next), 1);
        @(negedge clk);
        chk("gen_one_cycle", 32'(generate_next), 0);
        @(negedge clk);
        @(negedge clk);
        chk("valid_latency", 32'(out_valid), 1);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_sample", $signed(out_sample), mon_e.smp);
                chk("env_at_valid", 32'(env_level), 32'(mon_e.env));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_env", 32'(env_level), 0);
        chk("rst_gen", 32'(generate_next), 0);
        chk("rst_out_sample", 32'(out_sample), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;

        note(1'b1, 1'b0);
        chk("attack_entry", 32'(state), 1);
        for (int i = 0; i < 16; i++) begin
            req_step(i * 2000 - 15000);
            chk("attack_env", 32'(env_level), ((i + 1) * 16 > 255) ? 255 : (i + 1) * 16);
        end
        chk("sustain_state", 32'(state), 2);

        req_step(32767);
        chk("sustain_pos", $signed(out_sample), 32639);
        req_step(-32768);
        chk("sustain_neg", $signed(out_sample), -32640);
        req_step(0);
        chk("sustain_zero", $signed(out_sample), 0);
        chk("sustain_env_held", 32'(env_level), 255);

        note(1'b0, 1'b1);
        chk("release_entry", 32'(state), 3);
        for (int i = 0; i < 64; i++) begin
            req_step(int'($urandom_range(65535)) - 32768);
            chk("release_env", 32'(env_level), (255 - 4 * (i + 1) < 0) ? 0 : 255 - 4 * (i + 1));
        end
        chk("release_to_idle", 32'(state), 0);
        req_step(12345);
        chk("idle_zero_out", $signed(out_sample), 0);

        note(1'b1, 1'b1);
        chk("on_off_same_cycle", 32'(state), 0);

        note(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) req_step(int'($urandom_range(40000)) - 20000);
        chk("partial_attack", 32'(env_level), 112);
        note(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) req_step(int'($urandom_range(40000)) - 20000);
        chk("release_at_100", 32'(env_level), 100);
        chk("release_state", 32'(state), 3);
        note(1'b1, 1'b0);
        chk("retrigger_state", 32'(state), 1);
        chk("retrigger_env_kept", 32'(env_level), 100);
        req_step(-1234);
        chk("retrigger_env", 32'(env_level), 116);

        chk("overrun_clear", 32'(overrun), 0);
        begin
            exp_t e;
            @(negedge clk);
            sample = 16'(777);
            req = 1'b1;
            model_sample(777, e);
            sb.push_back(e);
            @(negedge clk);
            gcnt = int'(generate_next);
            vcnt = 0;
            repeat (8) begin
                @(negedge clk);
                req = 1'b0;
                gcnt += int'(generate_next);
                vcnt += int'(out_valid);
            end
        end
        chk("overrun_one_gen", gcnt, 1);
        chk("overrun_one_valid", vcnt, 1);
        chk("overrun_set", 32'(overrun), 1);
        req_step(3000);
        chk("overrun_sticky", 32'(overrun), 1);

        @(negedge clk);
        sample = 16'(5000);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("midrst_gen", 32'(generate_next), 1);
        @(negedge clk);
        rst_n = 1'b0;
        m_env = 0; m_st = 0;
        #1;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_env", 32'(env_level), 0);
        chk("midrst_gen0", 32'(generate_next), 0);
        chk("midrst_out_sample", 32'(out_sample), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_ready_seen", 32'(sample_ready), 1);
        vcnt = 0;
        repeat (4) begin
            @(negedge clk);
            vcnt += int'(out_valid);
        end
        chk("midrst_no_valid", vcnt, 0);
        req_step(20000);
        chk("post_rst_out", $signed(out_sample), 0);
        chk("post_rst_overrun", 32'(overrun), 0);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
